// File: rtl/trap_ctrl.sv
// Pipeline stall arbitration, trap/interrupt entry, mret return and
// redirect handshake toward the IFU, with CSR update strobes.
module trap_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              NUM_IRQ    = 16,
    parameter int              NUM_STAGES = 6,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  ck_i,
    input  logic                  rs_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_cause_i,
    input  logic [XLEN-1:0]       exc_tval_i,
    input  logic [XLEN-1:0]       exc_pc_i,
    input  logic                  mret_i,
    input  logic                  mstatus_ie_i,
    input  logic [NUM_IRQ-1:0]    irq_pending_i,
    input  logic [NUM_IRQ-1:0]    irq_enable_i,
    input  logic [XLEN-1:0]       mtvec_i,
    input  logic [XLEN-1:0]       mepc_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic                  new_pc_valid_o,
    input  logic                  new_pc_ready_i,
    output logic [XLEN-1:0]       new_pc_o,
    output logic                  set_cause_o,
    output logic [XLEN-1:0]       cause_o,
    output logic                  set_epc_o,
    output logic [XLEN-1:0]       epc_o,
    output logic                  set_mtval_o,
    output logic [XLEN-1:0]       mtval_o,
    output logic                  mie_clear_o,
    output logic                  mie_set_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_TAKE,
        S_RET,
        S_WAIT_T,
        S_WAIT_R
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [XLEN-1:0]       r_cause;
    logic [XLEN-1:0]       r_epc;
    logic [XLEN-1:0]       r_tval;
    logic [XLEN-1:0]       r_tgt;

    logic [NUM_IRQ-1:0]    w_act;
    logic                  w_irq;
    logic [4:0]            w_irq_idx;
    logic [XLEN-1:0]       w_irq_cause;
    logic [XLEN-1:0]       w_base;
    logic [XLEN-1:0]       w_vec;
    logic [XLEN-1:0]       w_ret_pc;
    logic [NUM_STAGES-1:0] w_mask;
    logic                  w_in_run;

    assign w_act    = irq_pending_i & irq_enable_i;
    assign w_irq    = mstatus_ie_i & (|w_act);
    assign w_in_run = (r_state == S_RUN);

    // Later (higher) lines overwrite earlier ones, so the top index wins.
    always_comb begin
        w_irq_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_act[i]) w_irq_idx = 5'(i);
        end
    end

    // A stalled stage must also hold every older stage behind it.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_mask[k] = |(stallreq_i >> k);
        end
    end

    assign w_irq_cause = {1'b1, {(XLEN-6){1'b0}}, w_irq_idx};
    assign w_base      = mtvec_i & ~XLEN'(3);
    assign w_vec       = (mtvec_i[1:0] == 2'b01)
                       ? w_base + {{(XLEN-7){1'b0}}, w_irq_idx, 2'b00}
                       : w_base;
    assign w_ret_pc    = mepc_i & ~XLEN'(3);

    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture happens only on the RUN decision edge; the target is held
    // for the whole redirect so the handshake stays stable.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            r_cause <= '0;
            r_epc   <= '0;
            r_tval  <= '0;
            r_tgt   <= '0;
        end else if (w_in_run) begin
            if (exc_valid_i) begin
                r_cause <= XLEN'(exc_cause_i);
                r_epc   <= exc_pc_i;
                r_tval  <= exc_tval_i;
                r_tgt   <= w_base;
            end else if (w_irq) begin
                r_cause <= w_irq_cause;
                r_epc   <= exc_pc_i;
                r_tval  <= '0;
                r_tgt   <= w_vec;
            end else if (mret_i) begin
                r_tgt   <= w_ret_pc;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        stall_o        = '1;
        flush_o        = 1'b0;
        new_pc_valid_o = 1'b0;
        new_pc_o       = '0;
        set_cause_o    = 1'b0;
        set_epc_o      = 1'b0;
        set_mtval_o    = 1'b0;
        mie_clear_o    = 1'b0;
        mie_set_o      = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                new_pc_valid_o = 1'b1;
                new_pc_o       = RESET_PC;
                if (new_pc_ready_i) w_next = S_RUN;
            end
            S_RUN: begin
                stall_o = w_mask;
                if (exc_valid_i || w_irq) w_next = S_TAKE;
                else if (mret_i)          w_next = S_RET;
            end
            S_TAKE: begin
                set_cause_o    = 1'b1;
                set_epc_o      = 1'b1;
                set_mtval_o    = 1'b1;
                mie_clear_o    = 1'b1;
                flush_o        = 1'b1;
                new_pc_valid_o = 1'b1;
                new_pc_o       = r_tgt;
                w_next = new_pc_ready_i ? S_RUN : S_WAIT_T;
            end
            S_RET: begin
                mie_set_o      = 1'b1;
                flush_o        = 1'b1;
                new_pc_valid_o = 1'b1;
                new_pc_o       = r_tgt;
                w_next = new_pc_ready_i ? S_RUN : S_WAIT_R;
            end
            S_WAIT_T, S_WAIT_R: begin
                flush_o        = 1'b1;
                new_pc_valid_o = 1'b1;
                new_pc_o       = r_tgt;
                if (new_pc_ready_i) w_next = S_RUN;
            end
            default: w_next = S_BOOT;
        endcase
    end

    assign cause_o = r_cause;
    assign epc_o   = r_epc;
    assign mtval_o = r_tval;

endmodule
